// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port, word-addressed data RAM between the CPU load/store
//   unit (port 0) and a secondary master (port 1). Round-robin arbitration,
//   byte/halfword/word accesses, sign/zero-extended sub-word loads and
//   read-modify-write sub-word stores.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   pN_req                 request, held until pN_ack
//   pN_we                  1 = store, 0 = load
//   pN_size                00 byte, 01 half, 10 word, 11 illegal
//   pN_unsigned            zero-extend loads when 1
//   pN_addr                byte address
//   pN_wdata               right-aligned store data
//   pN_ack/pN_err/pN_rdata one-cycle completion, error flag, load data
//   mem_wr_en/mem_addr/mem_wdata/mem_rdata   RAM port (combinational read)
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [1:0]            p0_size,
  input  logic                  p0_unsigned,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [31:0]           p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [1:0]            p1_size,
  input  logic                  p1_unsigned,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [31:0]           p1_rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            state;
  logic                  prio;     // port that wins when both request
  logic                  port_q;
  logic                  err_q;
  logic                  we_q;
  logic                  uns_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           merge_q;
  logic [31:0]           resp_q;

  logic any_req;
  logic gnt;
  logic req_err;
  logic sub_store;
  logic wr_word;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    r = '0;
    case (size)
      2'b00:   if (uns) r = {24'd0, b}; else r = b;
      2'b01:   if (uns) r = {16'd0, h}; else r = h;
      2'b10:   r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    if (size == 2'b00)
      r[{off, 3'b000} +: 8] = wdata[7:0];
    else if (size == 2'b01)
      r[{off[1], 4'b0000} +: 16] = wdata[15:0];
    return r;
  endfunction

  assign any_req   = p0_req | p1_req;
  // gnt = 1 selects port 1; the pointer only matters when both request
  assign gnt       = (p0_req & p1_req) ? prio : p1_req;
  assign req_err   = (size_q == 2'b11) ||
                     ((size_q == 2'b01) && addr_q[0]) ||
                     ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
  assign sub_store = we_q && (size_q != 2'b10);
  assign wr_word   = (state == S_ACCESS) && we_q && (size_q == 2'b10) && !req_err;

  // control: arbitration and sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      prio   <= 1'b0;
      port_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            port_q <= gnt;
            prio   <= ~gnt;
            state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          err_q <= req_err;
          state <= (!req_err && sub_store) ? S_WRITE : S_DONE;
        end
        S_WRITE: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // datapath: request latch, merge and response registers
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && any_req) begin
      we_q    <= gnt ? p1_we       : p0_we;
      size_q  <= gnt ? p1_size     : p0_size;
      uns_q   <= gnt ? p1_unsigned : p0_unsigned;
      addr_q  <= gnt ? p1_addr     : p0_addr;
      wdata_q <= gnt ? p1_wdata    : p0_wdata;
    end
    if (state == S_ACCESS) begin
      merge_q <= merge_lane(mem_rdata, wdata_q, size_q, addr_q[1:0]);
      resp_q  <= (!req_err && !we_q) ?
                 load_extract(mem_rdata, size_q, addr_q[1:0], uns_q) : 32'd0;
    end
  end

  // all outputs are decoded from registers and gated by state, so an
  // asynchronous reset returns them to zero immediately
  assign mem_wr_en = (state == S_WRITE) || wr_word;
  assign mem_addr  = ((state == S_ACCESS) || (state == S_WRITE)) ?
                     {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata = (state == S_WRITE) ? merge_q : (wr_word ? wdata_q : 32'd0);

  assign p0_ack   = (state == S_DONE) && !port_q;
  assign p1_ack   = (state == S_DONE) &&  port_q;
  assign p0_err   = p0_ack && err_q;
  assign p1_err   = p1_ack && err_q;
  assign p0_rdata = p0_ack ? resp_q : 32'd0;
  assign p1_rdata = p1_ack ? resp_q : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 0, p0_we = 0, p0_unsigned = 0;
  logic [1:0]    p0_size = 0;
  logic [AW-1:0] p0_addr = 0;
  logic [31:0]   p0_wdata = 0;
  logic          p1_req = 0, p1_we = 0, p1_unsigned = 0;
  logic [1:0]    p1_size = 0;
  logic [AW-1:0] p1_addr = 0;
  logic [31:0]   p1_wdata = 0;
  logic          p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .p1_rdata(p1_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM: 64 words, combinational read, write on rising edge
  logic [31:0] mem [64];
  logic        init_req = 1'b0;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(100 + i);
    end else if (mem_wr_en) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    bit [1:0]    size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [64];
  bit          last_port = 1'b1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input bit port, input bit we, input bit [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input bit err,
                              input logic [31:0] rd, input int lat, input int wr);
    vec_t v;
    v.port = port; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_err = err; v.exp_rdata = rd; v.exp_lat = lat; v.exp_wr = wr;
    return v;
  endfunction

  // Reference: what a request does to a flat byte-addressed memory image
  function automatic void model(inout vec_t v);
    int          w, off, nbytes, sh;
    logic [31:0] word, mask, val;
    w = int'(v.addr[7:2]);
    off = int'(v.addr[1:0]);
    v.exp_err = (v.size == 2'd3) || (v.size == 2'd1 && (off % 2) != 0) ||
                (v.size == 2'd2 && off != 0);
    v.exp_rdata = 0;
    v.exp_wr = 0;
    v.exp_lat = 2;
    if (!v.exp_err) begin
      nbytes = 1 << v.size;
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 32'd1;
      sh = 8 * off;
      word = ref_mem[w];
      if (!v.we) begin
        val = (word >> sh) & mask;
        if (!v.uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        v.exp_rdata = val;
      end else begin
        ref_mem[w] = (word & ~(mask << sh)) | ((v.wdata & mask) << sh);
        v.exp_wr = 1;
        v.exp_lat = (nbytes == 4) ? 2 : 3;
      end
    end
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    v.port = 1'($urandom_range(0, 1));
    v.we = 1'($urandom_range(0, 1));
    v.size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    v.uns = 1'($urandom_range(0, 1));
    v.addr = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 1) == 1) begin
      if (v.size == 2'd1) v.addr[0] = 1'b0;
      if (v.size == 2'd2) v.addr[1:0] = 2'b00;
    end
    v.wdata = $urandom;
    v.exp_err = 0; v.exp_rdata = 0; v.exp_lat = 0; v.exp_wr = 0;
    return v;
  endfunction

  task automatic drive(input bit port, input vec_t v, input bit req);
    if (!port) begin
      p0_req = req; p0_we = v.we; p0_size = v.size; p0_unsigned = v.uns;
      p0_addr = v.addr; p0_wdata = v.wdata;
    end else begin
      p1_req = req; p1_we = v.we; p1_size = v.size; p1_unsigned = v.uns;
      p1_addr = v.addr; p1_wdata = v.wdata;
    end
  endtask

  task automatic init_mem();
    init_req = 1'b1;
    @(posedge clk);
    #1 init_req = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(100 + i);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    init_mem();
    @(negedge clk);
    rst_n = 1'b1;
    last_port = 1'b1;
  endtask

  // Run one transaction (a) or two simultaneous ones (a is the expected first grant)
  task automatic run_txns(input vec_t a, input vec_t b, input bit two);
    bit   done_a, done_b, ap;
    int   n, na, wr;
    vec_t cur;
    @(posedge clk);
    #1;
    drive(a.port, a, 1'b1);
    if (two) drive(b.port, b, 1'b1);
    done_a = 0; done_b = !two; n = 0; na = 0; wr = 0;
    while (!(done_a && done_b) && n < 30) begin
      @(negedge clk);
      cur = done_a ? b : a;
      if (mem_wr_en) begin
        wr++;
        chk("mem_addr", mem_addr, {cur.addr[31:2], 2'b00});
      end
      if (p0_ack && p1_ack) chk("ack_overlap", 32'd1, 32'd0);
      if (p0_ack || p1_ack) begin
        ap = p1_ack;
        chk("other_rdata", ap ? p0_rdata : p1_rdata, 32'd0);
        chk("other_ack", 32'(ap ? p0_ack : p1_ack), 32'd0);
        chk("grant_port", 32'(ap), 32'(cur.port));
        chk("latency", 32'(n), done_a ? 32'(na + 1 + b.exp_lat) : 32'(a.exp_lat));
        chk("err", 32'(ap ? p1_err : p0_err), 32'(cur.exp_err));
        chk("rdata", ap ? p1_rdata : p0_rdata, cur.exp_rdata);
        chk("wr_cycles", 32'(wr), 32'(cur.exp_wr));
        drive(ap, cur, 1'b0);
        last_port = ap;
        wr = 0;
        if (!done_a) begin
          done_a = 1; na = n;
        end else begin
          done_b = 1;
        end
      end
      n++;
    end
    if (!(done_a && done_b)) begin
      chk("timeout", 32'd0, 32'd1);
      p0_req = 0; p1_req = 0;
    end
  endtask

  vec_t tbl [18];

  initial begin
    vec_t x, y, f, s;
    bit   got [4];
    int   nack, cyc;

    // reset state
    init_mem();
    chk("rst_p0_ack", 32'(p0_ack), 0);
    chk("rst_p1_ack", 32'(p1_ack), 0);
    chk("rst_p0_err", 32'(p0_err), 0);
    chk("rst_p1_err", 32'(p1_err), 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //          port we size uns addr    wdata          err rdata         lat wr
    tbl[0]  = mk(0, 0, 2'd2, 0, 32'h08, 32'h0,          0, 32'd102,       2, 0);
    tbl[1]  = mk(1, 1, 2'd0, 0, 32'h0D, 32'hAB,         0, 32'h0,         3, 1);
    tbl[2]  = mk(0, 0, 2'd2, 0, 32'h0C, 32'h0,          0, 32'h0000AB67,  2, 0);
    tbl[3]  = mk(1, 0, 2'd0, 0, 32'h0D, 32'h0,          0, 32'hFFFFFFAB,  2, 0);
    tbl[4]  = mk(0, 0, 2'd0, 1, 32'h0D, 32'h0,          0, 32'h000000AB,  2, 0);
    tbl[5]  = mk(1, 0, 2'd1, 0, 32'h0C, 32'h0,          0, 32'hFFFFAB67,  2, 0);
    tbl[6]  = mk(0, 0, 2'd1, 0, 32'h03, 32'h0,          1, 32'h0,         2, 0);
    tbl[7]  = mk(0, 1, 2'd2, 0, 32'h06, 32'h11111111,   1, 32'h0,         2, 0);
    tbl[8]  = mk(0, 0, 2'd2, 0, 32'h04, 32'h0,          0, 32'd101,       2, 0);
    tbl[9]  = mk(1, 0, 2'd3, 0, 32'h00, 32'h0,          1, 32'h0,         2, 0);
    tbl[10] = mk(1, 1, 2'd1, 0, 32'h12, 32'h1234ABCD,   0, 32'h0,         3, 1);
    tbl[11] = mk(0, 0, 2'd1, 1, 32'h12, 32'h0,          0, 32'h0000ABCD,  2, 0);
    tbl[12] = mk(0, 0, 2'd0, 0, 32'h13, 32'h0,          0, 32'hFFFFFFAB,  2, 0);
    tbl[13] = mk(0, 1, 2'd2, 0, 32'h20, 32'hDEADBEEF,   0, 32'h0,         2, 1);
    tbl[14] = mk(1, 0, 2'd2, 0, 32'h20, 32'h0,          0, 32'hDEADBEEF,  2, 0);
    tbl[15] = mk(1, 0, 2'd1, 0, 32'h10, 32'h0,          0, 32'h00000068,  2, 0);
    tbl[16] = mk(1, 1, 2'd0, 0, 32'h1F, 32'h00000080,   0, 32'h0,         3, 1);
    tbl[17] = mk(0, 0, 2'd0, 0, 32'h1F, 32'h0,          0, 32'hFFFFFF80,  2, 0);
    for (int i = 0; i < 18; i++) run_txns(tbl[i], tbl[i], 1'b0);

    // both ports hold req for four transactions: strict alternation from p0
    apply_reset();
    @(posedge clk);
    #1;
    drive(1'b0, mk(0, 0, 2'd2, 0, 32'h00, 0, 0, 0, 0, 0), 1'b1);
    drive(1'b1, mk(1, 0, 2'd2, 0, 32'h04, 0, 0, 0, 0, 0), 1'b1);
    nack = 0; cyc = 0;
    while (nack < 4 && cyc < 40) begin
      @(negedge clk);
      if (p0_ack && p1_ack) chk("rr_overlap", 32'd1, 32'd0);
      if (p0_ack || p1_ack) begin
        got[nack] = p1_ack;
        chk("rr_rdata", p1_ack ? p1_rdata : p0_rdata, p1_ack ? 32'd101 : 32'd100);
        chk("rr_other_rdata", p1_ack ? p0_rdata : p1_rdata, 32'd0);
        nack++;
      end
      cyc++;
    end
    p0_req = 0; p1_req = 0;
    if (nack < 4) chk("rr_timeout", 32'(nack), 32'd4);
    for (int i = 0; i < 4; i++) if (i < nack) chk("rr_order", 32'(got[i]), 32'(i % 2));
    last_port = 1'b1;

    // reset asserted in the WRITE cycle of a byte store
    @(posedge clk);
    #1;
    drive(1'b0, mk(0, 1, 2'd0, 0, 32'h10, 32'h55, 0, 0, 0, 0), 1'b1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_wr_en && cyc < 8);
    chk("write_phase_cycle", 32'(cyc), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", 32'(mem_wr_en), 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_ack", 32'(p0_ack), 0);
    p0_req = 0; p1_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ram_word4", mem[4], 32'd104);
    rst_n = 1'b1;
    last_port = 1'b1;
    run_txns(mk(0, 0, 2'd2, 0, 32'h10, 0, 0, 32'd104, 2, 0),
             mk(1, 0, 2'd2, 0, 32'h14, 0, 0, 32'd105, 2, 0), 1'b1);

    // randomized traffic against the reference model
    apply_reset();
    for (int it = 0; it < 200; it++) begin
      x = rnd_vec();
      if ($urandom_range(0, 2) == 0) begin
        y = rnd_vec();
        y.port = !x.port;
        if (x.port == !last_port) begin f = x; s = y; end
        else begin f = y; s = x; end
        model(f);
        model(s);
        run_txns(f, s, 1'b1);
        chk("ram_word", mem[f.addr[7:2]], ref_mem[f.addr[7:2]]);
        chk("ram_word", mem[s.addr[7:2]], ref_mem[s.addr[7:2]]);
      end else begin
        model(x);
        run_txns(x, x, 1'b0);
        chk("ram_word", mem[x.addr[7:2]], ref_mem[x.addr[7:2]]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
